// File: rtl/pll_reconfig_ctrl.sv
// PLL scan-chain reconfiguration: byte-addressed shadow serialised MSB-first into the PLL, or captured back from it.
// Requests are accepted only in IDLE (busy=0); every output is a flop, rd_data follows rd_addr by one cycle.
module pll_reconfig_ctrl #(
  parameter int CHAIN_LEN = 144,
  parameter int TIMEOUT   = 1023,
  parameter int AW        = $clog2(CHAIN_LEN/8)
) (
  input  logic          inclk0,
  input  logic          areset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          start,
  input  logic          read_back,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          scandata,
  output logic          scanclkena,
  output logic          scanwrite,
  output logic          scanread,
  output logic          configupdate,
  input  logic          scandataout,
  input  logic          scandone
);

  localparam int NBYTES  = CHAIN_LEN / 8;
  localparam int CNT_MAX = (CHAIN_LEN > TIMEOUT) ? CHAIN_LEN : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [AW:0]   NBYTES_W   = (AW+1)'(NBYTES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_STROBE = 3'd1,
    SHIFT     = 3'd2,
    WR_STROBE = 3'd3,
    WAIT_DONE = 3'd4,
    UPDATE    = 3'd5
  } stateT;

  stateT                state;
  stateT                stateNext;
  logic                 readMode;
  logic                 readModeNext;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cntNext;
  logic [CHAIN_LEN-1:0] shadow;
  logic [CHAIN_LEN-1:0] shadowNext;

  logic       wrInRange;
  logic       rdInRange;
  logic       busyD;
  logic       doneD;
  logic       errorD;
  logic       scandataD;
  logic       scanclkenaD;
  logic       scanwriteD;
  logic       scanreadD;
  logic       configupdateD;
  logic [7:0] rdDataD;

  assign wrInRange = ({1'b0, wr_addr} < NBYTES_W);
  assign rdInRange = ({1'b0, rd_addr} < NBYTES_W);

  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      readMode     <= 1'b0;
      cnt          <= '0;
      shadow       <= '0;
      rd_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      scandata     <= 1'b0;
      scanclkena   <= 1'b0;
      scanwrite    <= 1'b0;
      scanread     <= 1'b0;
      configupdate <= 1'b0;
    end else begin
      state        <= stateNext;
      readMode     <= readModeNext;
      cnt          <= cntNext;
      shadow       <= shadowNext;
      rd_data      <= rdDataD;
      busy         <= busyD;
      done         <= doneD;
      error        <= errorD;
      scandata     <= scandataD;
      scanclkena   <= scanclkenaD;
      scanwrite    <= scanwriteD;
      scanread     <= scanreadD;
      configupdate <= configupdateD;
    end
  end

  // start has priority over read_back; both are dropped outside IDLE
  always_comb begin
    stateNext    = state;
    readModeNext = readMode;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext    = SHIFT;
          readModeNext = 1'b0;
        end else if (read_back) begin
          stateNext    = RD_STROBE;
          readModeNext = 1'b1;
        end
      end
      RD_STROBE: stateNext = SHIFT;
      SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          stateNext = readMode ? IDLE : WR_STROBE;
        end
      end
      WR_STROBE: stateNext = WAIT_DONE;
      WAIT_DONE: begin
        if (scandone) begin
          stateNext = UPDATE;
        end else if (cnt == WAIT_LAST) begin
          stateNext = IDLE;
        end
      end
      UPDATE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Counter restarts from 0 on every state change, so it indexes cycles within SHIFT and WAIT_DONE
  always_comb begin
    cntNext = '0;
    if (state != IDLE && stateNext == state) begin
      cntNext = cnt + CW'(1);
    end
  end

  // In write mode the outgoing MSB re-enters at the LSB, leaving the shadow intact after a full pass
  always_comb begin
    shadowNext = shadow;
    if (state == IDLE) begin
      if (wr_en && wrInRange) begin
        shadowNext[{wr_addr, 3'b000} +: 8] = wr_data;
      end
    end else if (state == SHIFT) begin
      shadowNext = {shadow[CHAIN_LEN-2:0], readMode ? scandataout : shadow[CHAIN_LEN-1]};
    end
  end

  always_comb begin
    busyD         = (stateNext != IDLE);
    scanclkenaD   = (stateNext == RD_STROBE) || (stateNext == SHIFT) ||
                    (stateNext == WR_STROBE) || (stateNext == WAIT_DONE);
    scanwriteD    = (stateNext == WR_STROBE);
    scanreadD     = (stateNext == RD_STROBE);
    configupdateD = (stateNext == UPDATE);
    scandataD     = (stateNext == SHIFT) && shadowNext[CHAIN_LEN-1];
    doneD         = (state == UPDATE) || ((state == SHIFT) && readMode && (stateNext == IDLE));
    errorD        = (state == WAIT_DONE) && (stateNext == IDLE);
    rdDataD       = rdInRange ? shadow[{rd_addr, 3'b000} +: 8] : 8'h00;
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: a small PLL model answers the scan interface and a queue
// holds the scandata bits expected for every accepted write operation.
module tb_pll_reconfig_ctrl;

  localparam int CHAIN_LEN = 144;
  localparam int TIMEOUT   = 1023;
  localparam int AW        = 5;
  localparam int NB        = CHAIN_LEN / 8;

  logic          inclk0 = 1'b0;
  logic          areset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          start;
  logic          read_back;
  logic          busy;
  logic          done;
  logic          error;
  logic          scandata;
  logic          scanclkena;
  logic          scanwrite;
  logic          scanread;
  logic          configupdate;
  logic          scandataout;
  logic          scandone;

  always #5 inclk0 = ~inclk0;

  pll_reconfig_ctrl #(.CHAIN_LEN(CHAIN_LEN), .TIMEOUT(TIMEOUT), .AW(AW)) dut (
    .inclk0(inclk0), .areset(areset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .start(start), .read_back(read_back),
    .busy(busy), .done(done), .error(error),
    .scandata(scandata), .scanclkena(scanclkena), .scanwrite(scanwrite),
    .scanread(scanread), .configupdate(configupdate),
    .scandataout(scandataout), .scandone(scandone)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model [NB];
  logic       expQ [$];
  logic [7:0] pat = 8'hA5;

  int   cyc = 0;
  int   nWrite, nRead, nConfig, nDone, nError, nBoth;
  int   shiftCnt, waitCnt, readCnt, writeCyc, configCyc, doneCyc, sdCount;
  bit   capWrite, capRead, respond, waitPhase;
  logic [7:0] firstByte;
  logic busyAtError;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {busy, done, error, scandata, scanclkena, scanwrite, scanread, configupdate, rd_data};
  endfunction

  task automatic clearStats();
    nWrite = 0; nRead = 0; nConfig = 0; nDone = 0; nError = 0; nBoth = 0;
    shiftCnt = 0; waitCnt = 0; readCnt = 0; writeCyc = 0; configCyc = 0; doneCyc = 0;
    sdCount = 0; waitPhase = 0; busyAtError = 1'b1;
  endtask

  // One clock: outputs observed 1 time unit after the edge, PLL model inputs driven for the next edge
  task automatic step();
    @(posedge inclk0);
    #1;
    cyc++;
    scandone = 1'b0;
    if (sdCount > 0) begin
      sdCount--;
      if (sdCount == 0) scandone = 1'b1;
    end
    if (scanwrite) begin
      nWrite++;
      writeCyc  = cyc;
      capWrite  = 0;
      waitPhase = 1;
      if (respond) sdCount = 5;
    end else if (waitPhase && scanclkena) begin
      waitCnt++;
    end
    if (scanread) begin
      nRead++;
      readCnt = 0;
    end
    if (configupdate) begin
      nConfig++;
      configCyc = cyc;
      waitPhase = 0;
    end
    if (done) begin
      nDone++;
      doneCyc  = cyc;
      capWrite = 0;
      capRead  = 0;
    end
    if (error) begin
      nError++;
      busyAtError = busy;
      waitPhase   = 0;
    end
    if (done && error) nBoth++;
    if (capWrite && scanclkena && !scanwrite) begin
      if (shiftCnt < 8) firstByte = {firstByte[6:0], scandata};
      shiftCnt++;
      if (expQ.size() == 0) check("scandata_overrun", 32'(shiftCnt), 32'(CHAIN_LEN));
      else                  check("scandata", 32'(scandata), 32'(expQ.pop_front()));
    end
    scandataout = 1'b0;
    if (capRead && scanclkena && !scanread) begin
      scandataout = pat[7 - (readCnt % 8)];
      readCnt++;
    end
  endtask

  task automatic writeByte(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    if (a < NB) model[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic readByte(input string tag, input int a);
    rd_addr = AW'(a);
    step();
    check(tag, 32'(rd_data), (a < NB) ? 32'(model[a]) : 32'd0);
  endtask

  task automatic readAll(input string tag);
    for (int a = 0; a < NB; a++) readByte(tag, a);
  endtask

  task automatic issueStart(input bit rsp);
    respond   = rsp;
    shiftCnt  = 0;
    waitCnt   = 0;
    firstByte = 8'h00;
    capWrite  = 1;
    for (int i = CHAIN_LEN - 1; i >= 0; i--) expQ.push_back(model[i/8][i%8]);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    areset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    start = 1'b0; read_back = 1'b0; scandataout = 1'b0; scandone = 1'b0;
    capWrite = 0; capRead = 0; respond = 0; firstByte = 8'h00;
    foreach (model[i]) model[i] = 8'h00;
    clearStats();
    #12;
    check("reset_outputs", 32'(outs()), 32'd0);
    @(posedge inclk0);
    #1;
    areset = 1'b0;

    // Shadow load, out-of-range write/read, then a full write + configupdate
    for (int a = 0; a < NB; a++) writeByte(a, 8'(a + 1));
    writeByte(20, 8'h5A);
    readAll("shadow_load");
    readByte("rd_out_of_range", 20);
    clearStats();
    issueStart(1);
    waitIdle("wr_op_idle", 400);
    check("wr_shift_cycles", 32'(shiftCnt), 32'(CHAIN_LEN));
    check("wr_scanwrite_count", 32'(nWrite), 32'd1);
    check("wr_config_count", 32'(nConfig), 32'd1);
    check("wr_done_count", 32'(nDone), 32'd1);
    check("wr_error_count", 32'(nError), 32'd0);
    check("wr_config_latency", 32'(configCyc - writeCyc), 32'd6);
    check("wr_done_after_config", 32'(doneCyc - configCyc), 32'd1);
    check("wr_queue_drained", 32'(expQ.size()), 32'd0);
    readAll("wr_shadow_kept");

    // Read-back of a PLL chain holding 0xA5 in every byte
    clearStats();
    capRead = 1;
    read_back = 1'b1;
    step();
    read_back = 1'b0;
    check("rd_busy_rise", 32'(busy), 32'd1);
    waitIdle("rd_op_idle", 400);
    check("rd_scanread_count", 32'(nRead), 32'd1);
    check("rd_shift_cycles", 32'(readCnt), 32'(CHAIN_LEN));
    check("rd_done_count", 32'(nDone), 32'd1);
    check("rd_scanwrite_count", 32'(nWrite), 32'd0);
    check("rd_config_count", 32'(nConfig), 32'd0);
    foreach (model[i]) model[i] = 8'hA5;
    readAll("rd_shadow_a5");

    // start + read_back together, then start and wr_en while busy
    clearStats();
    read_back = 1'b1;
    issueStart(1);
    read_back = 1'b0;
    for (int i = 0; i < 20; i++) step();
    start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 8'h77;
    step();
    start = 1'b0; wr_en = 1'b0;
    waitIdle("both_op_idle", 400);
    check("both_scanwrite_count", 32'(nWrite), 32'd1);
    check("both_scanread_count", 32'(nRead), 32'd0);
    check("both_done_count", 32'(nDone), 32'd1);
    check("both_queue_drained", 32'(expQ.size()), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("busy_start_ignored", 32'(busy), 32'd0);
    check("busy_start_no_second_op", 32'(nWrite), 32'd1);
    readByte("busy_write_ignored", 0);

    // Same-cycle write of byte 17 with start: first eight bits out are ones
    clearStats();
    wr_en = 1'b1; wr_addr = AW'(17); wr_data = 8'hFF;
    model[17] = 8'hFF;
    issueStart(1);
    wr_en = 1'b0;
    waitIdle("same_cycle_idle", 400);
    check("same_cycle_first_byte", 32'(firstByte), 32'hFF);
    check("same_cycle_done_count", 32'(nDone), 32'd1);
    check("same_cycle_queue_drained", 32'(expQ.size()), 32'd0);

    // scandone never returned
    clearStats();
    issueStart(0);
    waitIdle("timeout_idle", 1500);
    check("timeout_wait_cycles", 32'(waitCnt), 32'(TIMEOUT));
    check("timeout_error_count", 32'(nError), 32'd1);
    check("timeout_config_count", 32'(nConfig), 32'd0);
    check("timeout_done_count", 32'(nDone), 32'd0);
    check("timeout_busy_at_error", 32'(busyAtError), 32'd0);
    step();
    check("timeout_busy_after", 32'(busy), 32'd0);
    check("timeout_error_pulse", 32'(error), 32'd0);
    check("timeout_queue_drained", 32'(expQ.size()), 32'd0);

    // Reset in the middle of SHIFT, then a normal operation straight after release
    clearStats();
    issueStart(1);
    for (int n = 0; n < 200 && shiftCnt < 70; n++) step();
    check("abort_reached_shift70", 32'(shiftCnt), 32'd70);
    #2;
    areset = 1'b1;
    #1;
    check("abort_outputs_async", 32'(outs()), 32'd0);
    capWrite = 0;
    expQ.delete();
    foreach (model[i]) model[i] = 8'h00;
    step();
    step();
    check("abort_no_pulses", 32'(nDone + nError + nConfig), 32'd0);
    areset = 1'b0;
    clearStats();
    issueStart(1);
    waitIdle("post_reset_idle", 400);
    check("post_reset_shift_cycles", 32'(shiftCnt), 32'(CHAIN_LEN));
    check("post_reset_done_count", 32'(nDone), 32'd1);
    check("post_reset_config_count", 32'(nConfig), 32'd1);
    check("post_reset_queue_drained", 32'(expQ.size()), 32'd0);
    readAll("post_reset_shadow_zero");
    check("done_error_overlap", 32'(nBoth), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- CHAIN_LEN, 144, PLL scan-chain length in bits; multiple of 8.
- TIMEOUT, 1023, max cycles to wait for scandone.
- AW, $clog2(CHAIN_LEN/8), shadow byte-address width.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- inclk0  in  1  sole clock.
- areset  in  1  reset, asynchronous, active-high.
- wr_en  in  1  shadow byte write strobe.
- wr_addr  in  AW  shadow byte address.
- wr_data  in  8  shadow byte data.
- rd_addr  in  AW  shadow byte read address.
- rd_data  out  8  shadow byte read data, registered.
- start  in  1  pulse: write shadow into PLL chain and reconfigure.
- read_back  in  1  pulse: read PLL chain into shadow.
- busy  out  1  operation in progress.
- done  out  1  1-cycle completion pulse.
- error  out  1  1-cycle scandone-timeout pulse.
- scandata  out  1  serial chain data to PLL.
- scanclkena  out  1  PLL scan-clock enable.
- scanwrite  out  1  PLL chain-write strobe.
- scanread  out  1  PLL chain-read strobe.
- configupdate  out  1  PLL configuration-update strobe.
- scandataout  in  1  serial chain data from PLL.
- scandone  in  1  PLL write-complete flag.

Function
REQ-003 The shadow register SHALL hold CHAIN_LEN bits; byte k = bits [8k+7:8k].
REQ-004 wr_en SHALL update the addressed byte at the next edge only when state=IDLE; writes while busy SHALL be ignored; out-of-range addresses SHALL be ignored.
REQ-005 rd_data SHALL equal the shadow byte at rd_addr with 1-cycle latency; out-of-range reads return 0.
REQ-006 The FSM states SHALL be IDLE, RD_STROBE, SHIFT, WR_STROBE, WAIT_DONE and UPDATE.
REQ-007 IDLE+start SHALL enter SHIFT (write mode); IDLE+read_back without start SHALL enter RD_STROBE; start SHALL win when both assert; both SHALL be ignored outside IDLE.
REQ-008 A same-cycle wr_en and start SHALL commit the write first, so the shifted data includes the new byte.
REQ-009 busy SHALL be 1 in every state except IDLE, and SHALL rise the cycle after the accepted request.
REQ-010 SHIFT SHALL last exactly CHAIN_LEN cycles with scanclkena=1 and scandata = bit CHAIN_LEN-1 first, descending.
REQ-011 The shadow SHALL rotate left each SHIFT cycle:
- Write mode: LSB takes the outgoing bit, so the shadow is unchanged after SHIFT.
- Read mode: LSB takes scandataout.
REQ-012 Write-mode SHIFT SHALL be followed by WR_STROBE: 1 cycle, scanwrite=1, scanclkena=1.
REQ-013 WAIT_DONE SHALL hold scanclkena=1 and count cycles from 0:
- scandone=1 -> UPDATE.
- Count reaching TIMEOUT without scandone -> IDLE with error=1 for one cycle, no configupdate, no done.
REQ-014 UPDATE SHALL assert configupdate for 1 cycle, then enter IDLE with done=1 for one cycle.
REQ-015 RD_STROBE SHALL assert scanread=1 and scanclkena=1 for 1 cycle, then enter read-mode SHIFT; read-mode SHIFT end -> IDLE with done=1; scanwrite and configupdate SHALL stay 0.
REQ-016 All strobes and scanclkena SHALL be registered outputs, 0 in IDLE; done and error SHALL never assert together.

Reset
REQ-017 areset=1 SHALL immediately force state IDLE, shadow all-zero, counters 0, and every output 0, including rd_data.
REQ-018 Reset mid-operation SHALL abort with no done, error or configupdate pulse; the first edge after deassertion SHALL accept requests.

Verification
REQ-019 Write bytes 0x01..0x12 at addresses 0..17, then start, with scandone returned 5 cycles after scanwrite -> 144 scandata bits MSB-first match, one scanwrite, one configupdate, then done; readback of the shadow is unchanged.
REQ-020 read_back with the PLL model shifting pattern 0xA5 repeated -> one scanread, 144 scanclkena cycles, done, every rd_data = 0xA5, no scanwrite.
REQ-021 start with scandone held 0 -> error after TIMEOUT cycles in WAIT_DONE, configupdate never asserted, busy=0 next cycle.
REQ-022 start and read_back in the same cycle -> write sequence runs; a second start during busy is ignored, and wr_en during busy leaves the shadow unchanged.
REQ-023 areset pulse at SHIFT cycle 70 -> all outputs 0 immediately, shadow 0, no done or error; a new start afterwards completes normally.
REQ-024 wr_en(addr 17, 0xFF) in the same cycle as start -> the first 8 scandata bits are all 1.
